dcache_flush_ctrl: RTL and testbench

DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

---
 rtl/dcache_flush_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dcache_flush_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_flush_ctrl.sv
// Data-cache flush engine: optional invalidate sweep after reset, then per-set
// read / scan / writeback of valid+dirty ways / invalidate on each flush request.
// Build option: define DCACHE_FLUSH_WB_PIPELINE_EN for up to 4 writebacks in flight.
module dcache_flush_ctrl #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    output logic                        flush_ack_o,
    input  logic                        stall_i,
    input  logic                        init_ni,
    output logic                        busy_o,
    output logic                        cpu_block_o,
    output logic                        meta_req_o,
    output logic                        meta_we_o,
    output logic [$clog2(NUM_SETS)-1:0] meta_idx_o,
    input  logic [NUM_WAYS-1:0]         meta_valid_i,
    input  logic [NUM_WAYS-1:0]         meta_dirty_i,
    output logic                        wb_req_o,
    input  logic                        wb_gnt_i,
    output logic [$clog2(NUM_SETS)-1:0] wb_idx_o,
    output logic [$clog2(NUM_WAYS)-1:0] wb_way_o,
    input  logic                        wb_done_i
);

    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        SCAN,
        WB,
        INV,
        DRAIN,
        ACK
    } state_t;

    state_t               state_q, state_d;
    logic [SET_W-1:0]     set_q, set_d;
    logic [NUM_WAYS-1:0]  mask_q, mask_d;
    logic [2:0]           outst_q, outst_d;
    logic                 sweep_q, sweep_d;

    logic [NUM_WAYS-1:0]  low_oh;
    logic                 wb_allow;
    logic                 wb_issue;
    logic                 wb_take;

    function automatic logic [WAY_W-1:0] onehot_to_way(input logic [NUM_WAYS-1:0] oh);
        logic [WAY_W-1:0] way;
        way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (oh[i]) begin
                way = WAY_W'(i);
            end
        end
        return way;
    endfunction

    // Isolate the lowest pending way: x & (-x).
    assign low_oh = mask_q & (~mask_q + NUM_WAYS'(1));

`ifdef DCACHE_FLUSH_WB_PIPELINE_EN
    assign wb_allow = (outst_q < 3'd4);
`else
    assign wb_allow = (outst_q == 3'd0);
`endif

    assign wb_issue = (state_q == WB) && (mask_q != '0) && wb_allow;
    assign wb_take  = wb_issue && wb_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            set_q   <= '0;
            mask_q  <= '0;
            outst_q <= '0;
            sweep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mask_q  <= mask_d;
            outst_q <= outst_d;
            sweep_q <= sweep_d;
        end
    end

    // A grant and a completion in the same cycle cancel; completion at zero is dropped.
    always_comb begin
        outst_d = outst_q;
        if (wb_take && !wb_done_i) begin
            outst_d = outst_q + 3'd1;
        end else if (!wb_take && wb_done_i && (outst_q != 3'd0)) begin
            outst_d = outst_q - 3'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        mask_d      = mask_q;
        sweep_d     = sweep_q;
        flush_ack_o = 1'b0;
        meta_req_o  = 1'b0;
        meta_we_o   = 1'b0;
        meta_idx_o  = '0;
        wb_req_o    = 1'b0;
        wb_idx_o    = '0;
        wb_way_o    = '0;

        case (state_q)
            INIT: begin
                // First cycle out of reset only decides; the sweep starts on the next one.
                if (!sweep_q) begin
                    if (init_ni) begin
                        state_d = IDLE;
                    end else begin
                        sweep_d = 1'b1;
                    end
                end else begin
                    meta_req_o = 1'b1;
                    meta_we_o  = 1'b1;
                    meta_idx_o = set_q;
                    set_d      = set_q + SET_W'(1);
                    if (set_q == LAST_SET) begin
                        sweep_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (flush_i) begin
                    set_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                meta_req_o = 1'b1;
                meta_idx_o = set_q;
                state_d    = SCAN;
            end
            SCAN: begin
                mask_d  = meta_valid_i & meta_dirty_i;
                state_d = ((meta_valid_i & meta_dirty_i) != '0) ? WB : INV;
            end
            WB: begin
                wb_req_o = wb_issue;
                wb_idx_o = set_q;
                wb_way_o = onehot_to_way(low_oh);
                if (wb_take) begin
                    mask_d = mask_q & ~low_oh;
                end
                if (mask_d == '0) begin
                    state_d = INV;
                end
            end
            INV: begin
                meta_req_o = 1'b1;
                meta_we_o  = 1'b1;
                meta_idx_o = set_q;
                set_d      = set_q + SET_W'(1);
                state_d    = (set_q == LAST_SET) ? DRAIN : RD;
            end
            DRAIN: begin
                if (outst_q == 3'd0) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                flush_ack_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE) || (outst_q != 3'd0);
    assign cpu_block_o = stall_i || (state_q != IDLE);

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with 4 sets x 8 ways, a metadata array
// model and a writeback responder (immediate grant, completion 3 cycles later).
module tb_dcache_flush_ctrl;

    localparam int NS = 4;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          flush_ack_o;
    logic          stall_i = 1'b0;
    logic          init_ni = 1'b1;
    logic          busy_o;
    logic          cpu_block_o;
    logic          meta_req_o;
    logic          meta_we_o;
    logic [1:0]    meta_idx_o;
    logic [NW-1:0] meta_valid_i;
    logic [NW-1:0] meta_dirty_i;
    logic          wb_req_o;
    logic          wb_gnt_i = 1'b0;
    logic [1:0]    wb_idx_o;
    logic [2:0]    wb_way_o;
    logic          wb_done_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [NW-1:0] cfg_valid [NS];
    logic [NW-1:0] cfg_dirty [NS];
    logic [1:0]    rd_idx = '0;

    logic          gnt_en = 1'b1;
    logic          auto_done = 1'b1;
    int            man_cnt = 0;
    int            man_used = 0;
    logic [2:0]    done_sr = '0;
    int            gnt_cnt = 0;
    logic [2:0]    gnt_way [16];
    int            done_cnt = 0;
    int            ack_cnt = 0;

    dcache_flush_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .flush_ack_o (flush_ack_o),
        .stall_i     (stall_i),
        .init_ni     (init_ni),
        .busy_o      (busy_o),
        .cpu_block_o (cpu_block_o),
        .meta_req_o  (meta_req_o),
        .meta_we_o   (meta_we_o),
        .meta_idx_o  (meta_idx_o),
        .meta_valid_i(meta_valid_i),
        .meta_dirty_i(meta_dirty_i),
        .wb_req_o    (wb_req_o),
        .wb_gnt_i    (wb_gnt_i),
        .wb_idx_o    (wb_idx_o),
        .wb_way_o    (wb_way_o),
        .wb_done_i   (wb_done_i)
    );

    always #5 clk = ~clk;

    // Metadata array: read data appears the cycle after the indexed access.
    always @(posedge clk) rd_idx <= meta_idx_o;
    assign meta_valid_i = cfg_valid[rd_idx];
    assign meta_dirty_i = cfg_dirty[rd_idx];

    always @(posedge clk) begin
        if (wb_done_i === 1'b1) done_cnt <= done_cnt + 1;
        if (flush_ack_o === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    always @(negedge clk) begin
        logic g;
        logic [3:0] gi;
        if (!rst_ni) begin
            done_sr   = '0;
            wb_gnt_i  = 1'b0;
            wb_done_i = 1'b0;
        end else begin
            g = gnt_en && (wb_req_o === 1'b1);
            wb_done_i = (auto_done && done_sr[2]) || (man_used != man_cnt);
            if (man_used != man_cnt) man_used++;
            done_sr  = {done_sr[1:0], g};
            wb_gnt_i = g;
            if (g) begin
                gi = gnt_cnt[3:0];
                gnt_way[gi] = wb_way_o;
                gnt_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        for (int s = 0; s < NS; s++) begin
            cfg_valid[s] = '0;
            cfg_dirty[s] = '0;
        end
    endtask

    task automatic do_reset(input logic skip);
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        init_ni = skip;
        repeat (2) tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        init_ni = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({busy_o, cpu_block_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_busy_block: got %b required 11", {busy_o, cpu_block_o});
        end
        vectors++;
        if ({flush_ack_o, meta_req_o, meta_we_o, wb_req_o, meta_idx_o, wb_idx_o, wb_way_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_zero: got %b required all zero",
                     {flush_ack_o, meta_req_o, meta_we_o, wb_req_o, meta_idx_o, wb_idx_o, wb_way_o});
        end
        rst_ni = 1'b1;
        vectors++;
        if ({busy_o, meta_we_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL skip_cycle1: busy,we got %b required 10", {busy_o, meta_we_o});
        end
        tick();
        vectors++;
        if ({busy_o, cpu_block_o, meta_we_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL skip_idle_cycle2: busy,block,we got %b required 000", {busy_o, cpu_block_o, meta_we_o});
        end
    endtask

    task automatic test_init_sweep();
        do_reset(1'b0);
        vectors++;
        if ({busy_o, meta_we_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL sweep_decide: busy,we got %b required 10", {busy_o, meta_we_o});
        end
        for (int i = 0; i < NS; i++) begin
            tick();
            vectors++;
            if ({meta_req_o, meta_we_o, meta_idx_o} !== {2'b11, 2'(i)}) begin
                miscompares++;
                $display("FAIL sweep_write_%0d: req,we,idx got %b required %b",
                         i, {meta_req_o, meta_we_o, meta_idx_o}, {2'b11, 2'(i)});
            end
        end
        tick();
        vectors++;
        if ({busy_o, meta_we_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL sweep_done_idle: busy,we got %b required 00", {busy_o, meta_we_o});
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        #1;
        vectors++;
        if ({cpu_block_o, busy_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_block: block,busy got %b required 10", {cpu_block_o, busy_o});
        end
        stall_i = 1'b0;
        #1;
        vectors++;
        if (cpu_block_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: block got %b required 0", cpu_block_o);
        end
    endtask

    // Flush sampled at edge 1 enters RD; each set takes 3 cycles, then DRAIN, then ACK.
    task automatic test_flush_clean();
        int n = 0;
        int rd = 0;
        int inv = 0;
        int blk = 0;
        clear_cfg();
        flush_i = 1'b1;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            tick();
            if (meta_req_o && !meta_we_o) rd++;
            if (meta_we_o) inv++;
            if (!cpu_block_o) blk++;
            if (flush_ack_o) n = c;
        end
        flush_i = 1'b0;
        vectors++;
        if (n !== 3 * NS + 2) begin
            miscompares++;
            $display("FAIL clean_ack_cycle: got %0d required %0d", n, 3 * NS + 2);
        end
        vectors++;
        if ((rd !== NS) || (inv !== NS) || (blk !== 0)) begin
            miscompares++;
            $display("FAIL clean_accesses: rd %0d inv %0d unblocked %0d required %0d %0d 0", rd, inv, blk, NS, NS);
        end
        tick();
        vectors++;
        if ({flush_ack_o, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL clean_ack_single: ack,busy got %b required 00", {flush_ack_o, busy_o});
        end
    endtask

    task automatic test_writeback();
        int bg = gnt_cnt;
        int bd = done_cnt;
        int got = 0;
        int bad_idx = 0;
        int dn = 0;
        clear_cfg();
        cfg_valid[1] = 8'hFF;
        cfg_valid[2] = 8'hFF;
        cfg_dirty[2] = 8'b0010_0001;
        cfg_dirty[3] = 8'hFF;
        flush_i = 1'b1;
        for (int c = 1; c <= 80 && got == 0; c++) begin
            tick();
            flush_i = 1'b0;
            if (wb_req_o && (wb_idx_o !== 2'd2)) bad_idx++;
            if (flush_ack_o) begin
                got = 1;
                dn = done_cnt - bd;
            end
        end
        vectors++;
        if (gnt_cnt - bg !== 2) begin
            miscompares++;
            $display("FAIL wb_grant_count: got %0d required 2", gnt_cnt - bg);
        end
        vectors++;
        if ({gnt_way[bg[3:0]], gnt_way[4'(bg + 1)]} !== {3'd0, 3'd5}) begin
            miscompares++;
            $display("FAIL wb_way_order: got %0d,%0d required 0,5", gnt_way[bg[3:0]], gnt_way[4'(bg + 1)]);
        end
        vectors++;
        if ((got !== 1) || (dn !== 2) || (bad_idx !== 0)) begin
            miscompares++;
            $display("FAIL wb_ack_after_done: ack %0d dones %0d badidx %0d required 1 2 0", got, dn, bad_idx);
        end
        tick();
    endtask

    task automatic test_inflight_limit();
        int bg = gnt_cnt;
        int bd = done_cnt;
        int got = 0;
`ifdef DCACHE_FLUSH_WB_PIPELINE_EN
        int lim = 4;
`else
        int lim = 1;
`endif
        clear_cfg();
        cfg_valid[1] = 8'hFF;
        cfg_dirty[1] = 8'h3F;
        auto_done = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (20) tick();
        vectors++;
        if ((gnt_cnt - bg !== lim) || (wb_req_o !== 1'b0) || (busy_o !== 1'b1)) begin
            miscompares++;
            $display("FAIL limit_stall: grants %0d req %b busy %b required %0d 0 1", gnt_cnt - bg, wb_req_o, busy_o, lim);
        end
        man_cnt++;
        repeat (3) tick();
        vectors++;
        if (gnt_cnt - bg !== lim + 1) begin
            miscompares++;
            $display("FAIL limit_resume: grants %0d required %0d", gnt_cnt - bg, lim + 1);
        end
        for (int c = 0; c < 300 && got == 0; c++) begin
            tick();
            if (flush_ack_o) got = 1;
            if ((man_used == man_cnt) && ((gnt_cnt - bg) > (done_cnt - bd))) man_cnt++;
        end
        vectors++;
        if ((got !== 1) || (gnt_cnt - bg !== 6)) begin
            miscompares++;
            $display("FAIL limit_complete: ack %0d grants %0d required 1 6", got, gnt_cnt - bg);
        end
        auto_done = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_wb();
        int ba;
        int seen = 0;
        clear_cfg();
        cfg_valid[0] = 8'hFF;
        cfg_dirty[0] = 8'h08;
        gnt_en  = 1'b0;
        flush_i = 1'b1;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            tick();
            if (wb_req_o) seen = 1;
        end
        vectors++;
        if ({wb_req_o, wb_way_o} !== {1'b1, 3'd3}) begin
            miscompares++;
            $display("FAIL midwb_request: req,way got %b required 1011", {wb_req_o, wb_way_o});
        end
        ba = ack_cnt;
        flush_i = 1'b0;
        init_ni = 1'b1;
        rst_ni  = 1'b0;
        #1;
        vectors++;
        if ({wb_req_o, busy_o, cpu_block_o} !== 3'b011) begin
            miscompares++;
            $display("FAIL midwb_reset_init: req,busy,block got %b required 011", {wb_req_o, busy_o, cpu_block_o});
        end
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (4) tick();
        vectors++;
        if ((ack_cnt !== ba) || (busy_o !== 1'b0)) begin
            miscompares++;
            $display("FAIL midwb_no_ack: acks %0d busy %b required %0d 0", ack_cnt, busy_o, ba);
        end
        gnt_en = 1'b1;
    endtask

    task automatic test_done_underflow();
        man_cnt++;
        repeat (3) tick();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL done_at_zero: busy got %b required 0", busy_o);
        end
    endtask

    initial begin
        clear_cfg();
        test_reset();
        test_init_sweep();
        test_stall();
        test_flush_clean();
        test_flush_clean();
        test_writeback();
        test_inflight_limit();
        test_reset_mid_wb();
        test_done_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
